// File: rtl/vga_timing_controller_if.sv
// Raster timing bundle from the VGA timing controller to pattern/image generators.
interface vga_timing_if;
  logic [10:0] HCNT;
  logic [10:0] VCNT;
  logic        IAA;
  logic        HS;
  logic        VS;
  logic        NEW_FRAME;

  modport master (output HCNT, VCNT, IAA, HS, VS, NEW_FRAME);
  modport slave  (input  HCNT, VCNT, IAA, HS, VS, NEW_FRAME);
endinterface

// File: rtl/vga_timing_controller.sv
// VGA raster timing: 1-based HCNT/VCNT, active-area flag, HS/VS sync, frame-start pulse.
// Optional VGA_TIMING_SYNC_DELAY_EN adds one register stage on HS/VS only.
module vga_timing_controller #(
  parameter int HORIZONTAL_VISIBLE_AREA = 640,
  parameter int H_FRONT_PORCH           = 16,
  parameter int H_SYNC_WIDTH            = 96,
  parameter int H_BACK_PORCH            = 48,
  parameter int VERTICAL_VISIBLE_AREA   = 480,
  parameter int V_FRONT_PORCH           = 10,
  parameter int V_SYNC_WIDTH            = 2,
  parameter int V_BACK_PORCH            = 33,
  parameter bit H_SYNC_POLARITY         = 1'b0,
  parameter bit V_SYNC_POLARITY         = 1'b0
) (
  input  logic          VGA_CLK,
  input  logic          rst,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = HORIZONTAL_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL = VERTICAL_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  localparam logic [10:0] H_VIS_END  = 11'(HORIZONTAL_VISIBLE_AREA);
  localparam logic [10:0] H_FP_END   = 11'(HORIZONTAL_VISIBLE_AREA + H_FRONT_PORCH);
  localparam logic [10:0] H_SYNC_END = 11'(HORIZONTAL_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_WIDTH);
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL);
  localparam logic [10:0] V_VIS_END  = 11'(VERTICAL_VISIBLE_AREA);
  localparam logic [10:0] V_FP_END   = 11'(VERTICAL_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [10:0] V_SYNC_END = 11'(VERTICAL_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_WIDTH);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL);

  typedef enum logic [1:0] {PH_VISIBLE, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

  function automatic phase_e decode(input logic [10:0] c, input logic [10:0] vis_end,
                                    input logic [10:0] fp_end, input logic [10:0] sync_end);
    if (c <= vis_end)       return PH_VISIBLE;
    else if (c <= fp_end)   return PH_FRONT;
    else if (c <= sync_end) return PH_SYNC;
    else                    return PH_BACK;
  endfunction

  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        iaa_q, iaa_d, nf_q, nf_d, hs_q, hs_d, vs_q, vs_d;
  phase_e      hph, vph;

  // hcnt_q == 0 only while/just after reset, so the first live edge lands on (1,1).
  always_comb begin
    hcnt_d = 11'd1;
    vcnt_d = vcnt_q;
    if (hcnt_q == 11'd0)        vcnt_d = 11'd1;
    else if (hcnt_q != H_LAST)  hcnt_d = hcnt_q + 11'd1;
    else                        vcnt_d = (vcnt_q == V_LAST) ? 11'd1 : vcnt_q + 11'd1;
  end

  // Outputs decode the next-state counters so every registered output describes one pixel.
  always_comb begin
    hph   = decode(hcnt_d, H_VIS_END, H_FP_END, H_SYNC_END);
    vph   = decode(vcnt_d, V_VIS_END, V_FP_END, V_SYNC_END);
    iaa_d = (hph == PH_VISIBLE) && (vph == PH_VISIBLE);
    nf_d  = (hcnt_d == 11'd1) && (vcnt_d == 11'd1);
    hs_d  = (hph == PH_SYNC) ? H_SYNC_POLARITY : ~H_SYNC_POLARITY;
    vs_d  = (vph == PH_SYNC) ? V_SYNC_POLARITY : ~V_SYNC_POLARITY;
  end

  always_ff @(posedge VGA_CLK or negedge rst) begin
    if (!rst) begin
      hcnt_q <= 11'd0;
      vcnt_q <= 11'd0;
      iaa_q  <= 1'b0;
      nf_q   <= 1'b0;
      hs_q   <= ~H_SYNC_POLARITY;
      vs_q   <= ~V_SYNC_POLARITY;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      iaa_q  <= iaa_d;
      nf_q   <= nf_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign vga.HCNT      = hcnt_q;
  assign vga.VCNT      = vcnt_q;
  assign vga.IAA       = iaa_q;
  assign vga.NEW_FRAME = nf_q;

`ifdef VGA_TIMING_SYNC_DELAY_EN
  // Extra stage lines sync up with the one-cycle clocked color ROM downstream.
  logic hs_dly_q, vs_dly_q;
  always_ff @(posedge VGA_CLK or negedge rst) begin
    if (!rst) begin
      hs_dly_q <= ~H_SYNC_POLARITY;
      vs_dly_q <= ~V_SYNC_POLARITY;
    end else begin
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;
    end
  end
  assign vga.HS = hs_dly_q;
  assign vga.VS = vs_dly_q;
`else
  assign vga.HS = hs_q;
  assign vga.VS = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_controller.sv
// Randomized-reset bench for vga_timing_controller: three geometries checked each cycle
// against an arithmetic raster model, plus literal pins on key boundaries.
module tb_vga_timing_controller;

  typedef struct {
    int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
    bit hp, vp;
  } geom_t;

  typedef struct {
    int h, v;
    bit iaa, hs, vs, nf;
  } exp_t;

  geom_t gA = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  geom_t gB = '{8, 1, 2, 1, 4, 1, 1, 1, 1'b1, 1'b1};
  geom_t gC = '{640, 16, 96, 48, 4, 1, 1, 1, 1'b0, 1'b0};

  logic clk, rst;
  int   n;
  int   total = 0, passed = 0, fails = 0;

  vga_timing_if ifA();
  vga_timing_if ifB();
  vga_timing_if ifC();

  vga_timing_controller dA (.VGA_CLK(clk), .rst(rst), .vga(ifA));
  vga_timing_controller #(
    .HORIZONTAL_VISIBLE_AREA(8), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .H_BACK_PORCH(1),
    .VERTICAL_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1),
    .H_SYNC_POLARITY(1'b1), .V_SYNC_POLARITY(1'b1)
  ) dB (.VGA_CLK(clk), .rst(rst), .vga(ifB));
  vga_timing_controller #(
    .VERTICAL_VISIBLE_AREA(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(1), .V_BACK_PORCH(1)
  ) dC (.VGA_CLK(clk), .rst(rst), .vga(ifC));

`ifdef VGA_TIMING_SYNC_DELAY_EN
  localparam int A_HS_FIRST = 658, A_HS_LAST = 753, B_HS_MIN = 11, B_HS_MAX = 12, B_VS_MAX = 7;
`else
  localparam int A_HS_FIRST = 657, A_HS_LAST = 752, B_HS_MIN = 10, B_HS_MAX = 11, B_VS_MAX = 6;
`endif

  // Pixel index n since reset release maps straight to a raster position.
  function automatic exp_t raw(geom_t g, int k);
    exp_t e;
    int ht, vt;
    ht = g.hv + g.hfp + g.hsw + g.hbp;
    vt = g.vv + g.vfp + g.vsw + g.vbp;
    if (k < 0) begin
      e.h = 0; e.v = 0; e.iaa = 0; e.nf = 0; e.hs = !g.hp; e.vs = !g.vp;
      return e;
    end
    e.h   = k % ht + 1;
    e.v   = (k / ht) % vt + 1;
    e.iaa = (e.h <= g.hv) && (e.v <= g.vv);
    e.nf  = (e.h == 1) && (e.v == 1);
    e.hs  = (e.h > g.hv + g.hfp && e.h <= g.hv + g.hfp + g.hsw) ? g.hp : !g.hp;
    e.vs  = (e.v > g.vv + g.vfp && e.v <= g.vv + g.vfp + g.vsw) ? g.vp : !g.vp;
    return e;
  endfunction

  function automatic exp_t model(geom_t g, int k);
    exp_t e;
    e = raw(g, k);
`ifdef VGA_TIMING_SYNC_DELAY_EN
    begin
      exp_t p;
      p = raw(g, (k < 0) ? -1 : k - 1);
      e.hs = p.hs;
      e.vs = p.vs;
    end
`endif
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else begin
      fails++;
      if (fails <= 40) $display("FAIL %s n=%0d actual=%0d expected=%0d", name, n, act, exp);
    end
  endtask

  task automatic cmp(string tag, geom_t g, int h, int v, logic iaa, logic hs, logic vs, logic nf);
    exp_t e;
    e = model(g, n);
    chk({tag, "_HCNT"}, h, e.h);
    chk({tag, "_VCNT"}, v, e.v);
    chk({tag, "_IAA"}, int'(iaa), int'(e.iaa));
    chk({tag, "_HS"}, int'(hs), int'(e.hs));
    chk({tag, "_VS"}, int'(vs), int'(e.vs));
    chk({tag, "_NF"}, int'(nf), int'(e.nf));
  endtask

  task automatic cmp_all();
    cmp("A", gA, int'(ifA.HCNT), int'(ifA.VCNT), ifA.IAA, ifA.HS, ifA.VS, ifA.NEW_FRAME);
    cmp("B", gB, int'(ifB.HCNT), int'(ifB.VCNT), ifB.IAA, ifB.HS, ifB.VS, ifB.NEW_FRAME);
    cmp("C", gC, int'(ifC.HCNT), int'(ifC.VCNT), ifC.IAA, ifC.HS, ifC.VS, ifC.NEW_FRAME);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= -1;
    else      n <= n + 1;
  end

  always @(negedge clk) cmp_all();

  initial begin
    #1_000_000;
    $display("FAIL watchdog n=%0d actual=timeout expected=finish", n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prev_h, prev_iaa, cyc;
    int hs_first, hs_last, b_hs_min, b_hs_max, b_vs_min, b_vs_max;
    int nf1, nf2, iaa_cnt, vs_cnt;
    bit did_fall, did_wrap, found;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_A_HCNT", int'(ifA.HCNT), 0);
    chk("rst_A_VCNT", int'(ifA.VCNT), 0);
    chk("rst_A_HS", int'(ifA.HS), 1);
    chk("rst_B_HS", int'(ifB.HS), 0);
    chk("rst_B_VS", int'(ifB.VS), 0);
    #2 rst = 1'b1;

    hs_first = -1; hs_last = -1;
    b_hs_min = 9999; b_hs_max = 0; b_vs_min = 9999; b_vs_max = 0;
    nf1 = -1; nf2 = -1; iaa_cnt = 0; vs_cnt = 0;
    did_fall = 0; did_wrap = 0;
    prev_h = 0; prev_iaa = 0;
    for (cyc = 0; cyc < 2 * 5600 + 20; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("start_A_HCNT", int'(ifA.HCNT), 1);
        chk("start_A_VCNT", int'(ifA.VCNT), 1);
        chk("start_A_IAA", int'(ifA.IAA), 1);
        chk("start_A_NF", int'(ifA.NEW_FRAME), 1);
        chk("start_A_HS", int'(ifA.HS), 1);
        chk("start_A_VS", int'(ifA.VS), 1);
      end
      if (!did_fall && prev_h == 640 && ifA.HCNT == 11'd641) begin
        did_fall = 1;
        chk("A_iaa_fall", prev_iaa * 2 + int'(ifA.IAA), 2);
      end
      if (!did_wrap && prev_h == 800) begin
        did_wrap = 1;
        chk("A_wrap_HCNT", int'(ifA.HCNT), 1);
        chk("A_wrap_VCNT", int'(ifA.VCNT), 2);
      end
      if (ifA.VCNT == 11'd1 && ifA.HS == 1'b0) begin
        if (hs_first < 0) hs_first = int'(ifA.HCNT);
        hs_last = int'(ifA.HCNT);
      end
      if (ifB.HS) begin
        if (int'(ifB.HCNT) < b_hs_min) b_hs_min = int'(ifB.HCNT);
        if (int'(ifB.HCNT) > b_hs_max) b_hs_max = int'(ifB.HCNT);
      end
      if (ifB.VS) begin
        if (int'(ifB.VCNT) < b_vs_min) b_vs_min = int'(ifB.VCNT);
        if (int'(ifB.VCNT) > b_vs_max) b_vs_max = int'(ifB.VCNT);
      end
      if (ifC.NEW_FRAME) begin
        if (nf1 < 0) nf1 = cyc;
        else if (nf2 < 0) nf2 = cyc;
      end
      if (nf1 >= 0 && nf2 < 0) begin
        iaa_cnt += int'(ifC.IAA);
        vs_cnt  += int'(!ifC.VS);
      end
      prev_h = int'(ifA.HCNT);
      prev_iaa = int'(ifA.IAA);
    end
    chk("A_iaa_fall_seen", int'(did_fall), 1);
    chk("A_hs_first", hs_first, A_HS_FIRST);
    chk("A_hs_last", hs_last, A_HS_LAST);
    chk("B_hs_min", b_hs_min, B_HS_MIN);
    chk("B_hs_max", b_hs_max, B_HS_MAX);
    chk("B_vs_min", b_vs_min, 6);
    chk("B_vs_max", b_vs_max, B_VS_MAX);
    chk("C_nf_period", nf2 - nf1, 5600);
    chk("C_iaa_per_frame", iaa_cnt, 2560);
    chk("C_vs_per_frame", vs_cnt, 800);

    // Asynchronous reset mid-line on the default geometry.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ifA.HCNT == 11'd300) found = 1;
    end
    chk("A_reach_300", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_A_HCNT", int'(ifA.HCNT), 0);
    chk("async_A_VCNT", int'(ifA.VCNT), 0);
    chk("async_A_IAA", int'(ifA.IAA), 0);
    chk("async_A_HS", int'(ifA.HS), 1);
    cmp_all();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("restart_A_HCNT", int'(ifA.HCNT), 1);
    chk("restart_A_VCNT", int'(ifA.VCNT), 1);
    chk("restart_A_NF", int'(ifA.NEW_FRAME), 1);
    @(negedge clk);
    chk("restart_A_HCNT2", int'(ifA.HCNT), 2);
    chk("restart_A_NF2", int'(ifA.NEW_FRAME), 0);

    // Random run lengths and random reset pulse placement within the low clock phase.
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(1, 400)) @(negedge clk);
      #($urandom_range(1, 3)) rst = 1'b0;
      #1 cmp_all();
      repeat ($urandom_range(1, 3)) @(negedge clk);
      #2 rst = 1'b1;
    end
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
